// File: rtl/alu_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctl_pkg
// Brief   : Shared ALUOp encoding, opcode and ALU control-code constants.
// Revision: 1.0 - initial release
// ============================================================================
package alu_ctl_pkg;

  localparam int OPC_W = 11;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    LDST   = 2'b00,
    BRANCH = 2'b01,
    RTYPE  = 2'b10,
    RSVD   = 2'b11
  } aluop_e;

  localparam logic [OPC_W-1:0] OPC_ADD = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR = 11'b10101010000;
  localparam logic [OPC_W-1:0] OPC_EOR = 11'b11001010000;
  localparam logic [OPC_W-1:0] OPC_LSL = 11'b11010011011;
  localparam logic [OPC_W-1:0] OPC_LSR = 11'b11010011010;
  localparam logic [OPC_W-1:0] OPC_ORN = 11'b10101010001;

  localparam logic [CNT_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [CNT_W-1:0] ALU_ORR   = 4'b0001;
  localparam logic [CNT_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [CNT_W-1:0] ALU_EOR   = 4'b0011;
  localparam logic [CNT_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [CNT_W-1:0] ALU_PASSB = 4'b0111;
  localparam logic [CNT_W-1:0] ALU_LSL   = 4'b1000;
  localparam logic [CNT_W-1:0] ALU_LSR   = 4'b1001;
  localparam logic [CNT_W-1:0] ALU_NOR   = 4'b1100;

endpackage
`default_nettype wire

// File: rtl/alu_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_control_unit_if
// Brief   : Decode request (en/opCode/ALUOp) and registered result bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_control_unit_if;
  import alu_ctl_pkg::*;

  logic             en;
  logic [OPC_W-1:0] opCode;
  logic [1:0]       ALUOp;
  logic [CNT_W-1:0] ALUCnt;
  logic             illegal;

  modport master (output en, output opCode, output ALUOp,
                  input  ALUCnt, input illegal);
  modport slave  (input  en, input  opCode, input  ALUOp,
                  output ALUCnt, output illegal);

endinterface
`default_nettype wire

// File: rtl/alu_ctl_decode.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctl_decode
// Brief   : Combinational opCode/ALUOp -> {ALU code, illegal}.
//           ALUCTL_EXT_OPS_EN adds EOR/LSL/LSR/ORN to the R-type decode.
// Revision: 1.0 - initial release
// ============================================================================
module alu_ctl_decode
  import alu_ctl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [1:0]       i_aluop,
  output logic [CNT_W-1:0] o_code,
  output logic             o_illegal
);

  always_comb begin
    o_code    = ALU_ADD;
    o_illegal = 1'b0;
    case (aluop_e'(i_aluop))
      LDST:   o_code = ALU_ADD;
      BRANCH: o_code = ALU_PASSB;
      RTYPE: begin
        case (i_opcode)
          OPC_ADD: o_code = ALU_ADD;
          OPC_SUB: o_code = ALU_SUB;
          OPC_AND: o_code = ALU_AND;
          OPC_ORR: o_code = ALU_ORR;
`ifdef ALUCTL_EXT_OPS_EN
          OPC_EOR: o_code = ALU_EOR;
          OPC_LSL: o_code = ALU_LSL;
          OPC_LSR: o_code = ALU_LSR;
          OPC_ORN: o_code = ALU_NOR;
`else
`endif
          default: begin
            o_code    = ALU_ADD;
            o_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        o_code    = ALU_ADD;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : alu_control_unit
// Brief   : ALU control decode registered at the ID/EX boundary, with stall
//           hold (en) and async active-low reset. Honors ALUCTL_EXT_OPS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module alu_control_unit
  import alu_ctl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  alu_control_unit_if.slave    bus
);

  logic [CNT_W-1:0] w_code;
  logic             w_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;

  alu_ctl_decode u_decode (
    .i_opcode  (bus.opCode),
    .i_aluop   (bus.ALUOp),
    .o_code    (w_code),
    .o_illegal (w_illegal)
  );

  // en low is a pipeline stall: hold the last decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= ALU_ADD;
      r_illegal <= 1'b0;
    end else if (bus.en) begin
      r_cnt     <= w_code;
      r_illegal <= w_illegal;
    end
  end

  assign bus.ALUCnt  = r_cnt;
  assign bus.illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_control_unit
// Brief   : Directed-vector scoreboard bench for alu_control_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_control_unit;

  typedef struct {
    logic        en;
    logic [1:0]  aluop;
    logic [10:0] opc;
    logic [3:0]  cnt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [3:0] cnt;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vecs[$];

  alu_control_unit_if bus ();

  alu_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] cnt, input logic ill);
    n_vec++;
    if (bus.ALUCnt !== cnt || bus.illegal !== ill) begin
      n_err++;
      $display("FAIL %s: got ALUCnt=%b illegal=%b, want ALUCnt=%b illegal=%b",
               name, bus.ALUCnt, bus.illegal, cnt, ill);
    end
  endtask

  // Monitor: every captured cycle is compared against the oldest expectation
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("vector", e.cnt, e.ill);
    end
  end

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.en     = v.en;
    bus.ALUOp  = v.aluop;
    bus.opCode = v.opc;
    e.cnt = v.cnt;
    e.ill = v.ill;
    sb.push_back(e);
  endtask

  task automatic add(input logic en, input logic [1:0] op, input logic [10:0] opc,
                     input logic [3:0] cnt, input logic ill);
    vec_t v;
    v.en = en; v.aluop = op; v.opc = opc; v.cnt = cnt; v.ill = ill;
    vecs.push_back(v);
  endtask

  initial begin
    bus.en     = 1'b1;
    bus.ALUOp  = 2'b10;
    bus.opCode = 11'b11001011000;

    add(1, 2'b00, 11'b11010101011, 4'b0010, 0);
    add(1, 2'b01, 11'b10101001101, 4'b0111, 0);
    add(1, 2'b10, 11'b10001011000, 4'b0010, 0);
    add(1, 2'b10, 11'b11001011000, 4'b0110, 0);
    add(1, 2'b10, 11'b10001010000, 4'b0000, 0);
    add(1, 2'b10, 11'b10101010000, 4'b0001, 0);
    add(1, 2'b10, 11'b11111000010, 4'b0010, 1);
    add(1, 2'b01, 11'b11111111111, 4'b0111, 0);
    add(1, 2'b11, 11'b10001011000, 4'b0010, 1);
    add(1, 2'b00, 11'b00000000000, 4'b0010, 0);
    add(1, 2'b11, 11'b00000000000, 4'b0010, 1);
    // stall: SUB loaded, then inputs change to AND while en=0
    add(1, 2'b10, 11'b11001011000, 4'b0110, 0);
    add(0, 2'b10, 11'b10001010000, 4'b0110, 0);
    add(0, 2'b11, 11'b10001010000, 4'b0110, 0);
    add(1, 2'b10, 11'b10001010000, 4'b0000, 0);
`ifdef ALUCTL_EXT_OPS_EN
    add(1, 2'b10, 11'b11001010000, 4'b0011, 0);
    add(1, 2'b10, 11'b11010011011, 4'b1000, 0);
    add(1, 2'b10, 11'b11010011010, 4'b1001, 0);
    add(1, 2'b10, 11'b10101010001, 4'b1100, 0);
`else
    add(1, 2'b10, 11'b11001010000, 4'b0010, 1);
    add(1, 2'b10, 11'b11010011011, 4'b0010, 1);
    add(1, 2'b10, 11'b11010011010, 4'b0010, 1);
    add(1, 2'b10, 11'b10101010001, 4'b0010, 1);
`endif
    add(1, 2'b10, 11'b10101010000, 4'b0001, 0);

    // Power-on reset with en=1 and a decodable SUB on the inputs
    #12;
    check("reset_initial", 4'b0010, 1'b0);
    @(posedge clk); #2;
    check("reset_hold_initial", 4'b0010, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Mid-run async reset: load SUB, then pull reset between edges
    begin
      vec_t v;
      v.en = 1; v.aluop = 2'b10; v.opc = 11'b11001011000; v.cnt = 4'b0110; v.ill = 0;
      apply(v);
    end
    @(posedge clk); #3;
    bus.opCode = 11'b10101010000;
    rst_n = 1'b0;
    #1;
    check("reset_async", 4'b0010, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_en1", 4'b0010, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t v;
      v.en = 1; v.aluop = 2'b10; v.opc = 11'b10101010000; v.cnt = 4'b0001; v.ill = 0;
      apply(v);
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
